// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: requester port identifiers and
// the memory read latency assumed by the read-return path.
package mem_arbiter_pkg;

   typedef enum logic {
      PORT_HOST = 1'b0,
      PORT_GPU  = 1'b1
   } port_e;

   localparam int MEM_RD_LAT = 1;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the single-port byte memory between the host command
// controller and the GPU sprite engine: round-robin with a bounded GPU burst lock.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        h_req,
   input  logic        h_we,
   input  logic [15:0] h_addr,
   input  logic [7:0]  h_wdata,
   output logic        h_ack,
   output logic        h_rvalid,
   output logic [7:0]  h_rdata,
   input  logic        g_req,
   input  logic        g_we,
   input  logic [15:0] g_addr,
   input  logic [7:0]  g_wdata,
   output logic        g_ack,
   output logic        g_rvalid,
   output logic [7:0]  g_rdata,
   input  logic        g_lock,
   output logic        mem_read,
   output logic        mem_write,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_write_byte,
   input  logic [7:0]  mem_read_byte
);

   localparam int                CNT_W     = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   port_e             last_q, last_d;
   logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
   logic              h_pend_q, h_pend_d, g_pend_q, g_pend_d;
   logic              h_rvalid_q, h_rvalid_d, g_rvalid_q, g_rvalid_d;
   logic [7:0]        h_rdata_q, h_rdata_d, g_rdata_q, g_rdata_d;
   logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
   logic [15:0]       mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wbyte_q, mem_wbyte_d;

   logic              grant_h, grant_g, at_limit, lock_on;
   port_e             win;

   // Winner select. The lock only counts once the GPU actually holds a grant
   // streak (burst_cnt != 0), and the burst limit overrides it.
   always_comb begin
      grant_h  = 1'b0;
      grant_g  = 1'b0;
      at_limit = (burst_cnt_q == BURST_MAX);
      lock_on  = g_lock && g_req && (last_q == PORT_GPU) && (burst_cnt_q != '0);
      if (rst_n) begin
         if (h_req && g_req) begin
            if (lock_on && !at_limit) begin
               grant_g = 1'b1;
            end else if (last_q == PORT_HOST) begin
               grant_g = 1'b1;
            end else begin
               grant_h = 1'b1;
            end
         end else begin
            grant_h = h_req;
            grant_g = g_req;
         end
      end
   end

   assign h_ack = grant_h;
   assign g_ack = grant_g;
   assign win   = grant_g ? PORT_GPU : PORT_HOST;

   always_comb begin
      last_d      = last_q;
      burst_cnt_d = burst_cnt_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wbyte_d = mem_wbyte_q;
      h_pend_d    = 1'b0;
      g_pend_d    = 1'b0;
      if (grant_h || grant_g) begin
         last_d = win;
         if ((win == last_q) && (burst_cnt_q != '0)) begin
            burst_cnt_d = at_limit ? burst_cnt_q : burst_cnt_q + CNT_ONE;
         end else begin
            burst_cnt_d = CNT_ONE;
         end
         mem_write_d = grant_g ? g_we : h_we;
         mem_read_d  = !mem_write_d;
         mem_addr_d  = grant_g ? g_addr : h_addr;
         if (mem_write_d) begin
            mem_wbyte_d = grant_g ? g_wdata : h_wdata;
         end
         h_pend_d = grant_h && !h_we;
         g_pend_d = grant_g && !g_we;
      end
      // Memory returns data one cycle after the strobe; the held copy keeps the
      // last delivered byte visible between pulses.
      h_rvalid_d = h_pend_q;
      g_rvalid_d = g_pend_q;
      h_rdata_d  = h_rvalid_q ? mem_read_byte : h_rdata_q;
      g_rdata_d  = g_rvalid_q ? mem_read_byte : g_rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q      <= PORT_GPU;
         burst_cnt_q <= '0;
         h_pend_q    <= 1'b0;
         g_pend_q    <= 1'b0;
         h_rvalid_q  <= 1'b0;
         g_rvalid_q  <= 1'b0;
         h_rdata_q   <= '0;
         g_rdata_q   <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wbyte_q <= '0;
      end else begin
         last_q      <= last_d;
         burst_cnt_q <= burst_cnt_d;
         h_pend_q    <= h_pend_d;
         g_pend_q    <= g_pend_d;
         h_rvalid_q  <= h_rvalid_d;
         g_rvalid_q  <= g_rvalid_d;
         h_rdata_q   <= h_rdata_d;
         g_rdata_q   <= g_rdata_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wbyte_q <= mem_wbyte_d;
      end
   end

   assign h_rvalid       = h_rvalid_q;
   assign g_rvalid       = g_rvalid_q;
   assign h_rdata        = h_rvalid_q ? mem_read_byte : h_rdata_q;
   assign g_rdata        = g_rvalid_q ? mem_read_byte : g_rdata_q;
   assign mem_read       = mem_read_q;
   assign mem_write      = mem_write_q;
   assign mem_addr       = mem_addr_q;
   assign mem_write_byte = mem_wbyte_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed command lists per port, expected
// grant order queued up front, a negedge monitor checking acks, strobes and reads.
module tb_mem_arbiter;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  rexp;
   } cmd_t;

   typedef struct packed {
      logic port;
      cmd_t cmd;
   } grant_t;

   typedef struct packed {
      cmd_t cmd;
      int   due;
   } memop_t;

   typedef struct packed {
      logic [7:0] data;
      int         due;
   } rd_t;

   logic        clk, rst_n;
   logic        h_req, h_we, h_ack, h_rvalid;
   logic [15:0] h_addr;
   logic [7:0]  h_wdata, h_rdata;
   logic        g_req, g_we, g_ack, g_rvalid, g_lock;
   logic [15:0] g_addr;
   logic [7:0]  g_wdata, g_rdata;
   logic        mem_read, mem_write;
   logic [15:0] mem_addr;
   logic [7:0]  mem_write_byte, mem_read_byte;

   cmd_t   hq[$], gq[$], hexp[$], gexp[$];
   grant_t exp_grant[$];
   memop_t memq[$];
   rd_t    hrq[$], grq[$];

   int         checks = 0;
   int         fails  = 0;
   int         cyc    = 0;
   logic [7:0] h_last, g_last;

   logic [7:0] mem [0:65535];
   bit         written [0:65535];

   mem_arbiter #(.MAX_BURST(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
      .h_ack(h_ack), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
      .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
      .g_ack(g_ack), .g_rvalid(g_rvalid), .g_rdata(g_rdata), .g_lock(g_lock),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_write_byte(mem_write_byte), .mem_read_byte(mem_read_byte)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic logic [7:0] init_byte(input logic [15:0] a);
      case (a)
         16'h0010: return 8'hA5;
         16'h0200: return 8'h77;
         16'h0100: return 8'h11;
         16'h0101: return 8'h22;
         16'h0102: return 8'h33;
         16'h0103: return 8'h44;
         default:  return (a[15:8] == 8'h03) ? 8'h80 + a[7:0] : 8'h00;
      endcase
   endfunction

   // Synchronous byte memory: read data appears the cycle after mem_read.
   initial begin
      mem_read_byte = 8'h00;
      forever begin
         @(posedge clk);
         if (mem_write) begin
            mem[mem_addr]     <= mem_write_byte;
            written[mem_addr] <= 1'b1;
         end
         if (mem_read) begin
            mem_read_byte <= written[mem_addr] ? mem[mem_addr] : init_byte(mem_addr);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: consumes the expected grant order and derives timed expectations.
   initial begin
      grant_t gr;
      memop_t m;
      rd_t    r;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (h_ack || g_ack) begin
               chk("ack exclusive", 64'(h_ack && g_ack), 64'(0));
               if (exp_grant.size() == 0) begin
                  chk("unexpected ack", 64'(1), 64'(0));
               end else begin
                  gr = exp_grant.pop_front();
                  chk("grant port", 64'(g_ack), 64'(gr.port));
                  memq.push_back('{cmd: gr.cmd, due: cyc + 1});
                  if (!gr.cmd.we) begin
                     if (gr.port) grq.push_back('{data: gr.cmd.rexp, due: cyc + 2});
                     else         hrq.push_back('{data: gr.cmd.rexp, due: cyc + 2});
                  end
               end
            end
            if (mem_read || mem_write) begin
               if (memq.size() == 0) begin
                  chk("unexpected mem op", 64'(1), 64'(0));
               end else begin
                  m = memq.pop_front();
                  chk("mem op cycle", 64'(cyc), 64'(m.due));
                  chk("mem op", 64'({mem_write, mem_read, mem_addr, mem_write ? mem_write_byte : 8'h00}),
                      64'({m.cmd.we, !m.cmd.we, m.cmd.addr, m.cmd.we ? m.cmd.wdata : 8'h00}));
               end
            end
            if (h_rvalid) begin
               if (hrq.size() == 0) begin
                  chk("unexpected h_rvalid", 64'(1), 64'(0));
               end else begin
                  r = hrq.pop_front();
                  chk("h_rvalid cycle", 64'(cyc), 64'(r.due));
                  chk("h_rdata", 64'(h_rdata), 64'(r.data));
               end
               if (!g_rvalid) chk("g_rdata hold", 64'(g_rdata), 64'(g_last));
               h_last = h_rdata;
            end
            if (g_rvalid) begin
               if (grq.size() == 0) begin
                  chk("unexpected g_rvalid", 64'(1), 64'(0));
               end else begin
                  r = grq.pop_front();
                  chk("g_rvalid cycle", 64'(cyc), 64'(r.due));
                  chk("g_rdata", 64'(g_rdata), 64'(r.data));
               end
               if (!h_rvalid) chk("h_rdata hold", 64'(h_rdata), 64'(h_last));
               g_last = g_rdata;
            end
         end
      end
   end

   task automatic push_h(input logic we, input logic [15:0] a, input logic [7:0] wd, input logic [7:0] re);
      hq.push_back('{we: we, addr: a, wdata: wd, rexp: re});
      hexp.push_back('{we: we, addr: a, wdata: wd, rexp: re});
   endtask

   task automatic push_g(input logic we, input logic [15:0] a, input logic [7:0] wd, input logic [7:0] re);
      gq.push_back('{we: we, addr: a, wdata: wd, rexp: re});
      gexp.push_back('{we: we, addr: a, wdata: wd, rexp: re});
   endtask

   task automatic expect_grants(input string pat);
      for (int i = 0; i < pat.len(); i++) begin
         if (pat[i] == "H") exp_grant.push_back('{port: 1'b0, cmd: hexp.pop_front()});
         else               exp_grant.push_back('{port: 1'b1, cmd: gexp.pop_front()});
      end
   endtask

   task automatic flush_scoreboard();
      exp_grant.delete();
      memq.delete();
      hrq.delete();
      grq.delete();
      h_last = 8'h00;
      g_last = 8'h00;
   endtask

   task automatic check_reset_outputs(input string name);
      chk(name, 64'({mem_read, mem_write, mem_addr, mem_write_byte, h_rvalid, g_rvalid,
                    h_rdata, g_rdata, h_ack, g_ack}), 64'(0));
   endtask

   // Requests are asserted with both ports pending during reset to show acks stay low.
   task automatic apply_reset(input string name);
      rst_n = 1'b0;
      h_req = 1'b1;
      g_req = 1'b1;
      g_lock = 1'b0;
      flush_scoreboard();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs(name);
      h_req = 1'b0;
      g_req = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic run(input string name, input int exp_cycles);
      int   n = 0;
      logic ht, gt;
      while ((hq.size() != 0 || gq.size() != 0) && n < 200) begin
         h_req = (hq.size() != 0);
         if (h_req) {h_we, h_addr, h_wdata} = {hq[0].we, hq[0].addr, hq[0].wdata};
         g_req = (gq.size() != 0);
         if (g_req) {g_we, g_addr, g_wdata} = {gq[0].we, gq[0].addr, gq[0].wdata};
         @(negedge clk);
         ht = h_ack;
         gt = g_ack;
         @(posedge clk);
         #1;
         if (ht) void'(hq.pop_front());
         if (gt) void'(gq.pop_front());
         n++;
      end
      h_req = 1'b0;
      g_req = 1'b0;
      chk({name, " cycles"}, 64'(n), 64'(exp_cycles));
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      chk({name, " drained"}, 64'(exp_grant.size() + memq.size() + hrq.size() + grq.size()), 64'(0));
      hq.delete();
      gq.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
      g_req = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0;
      g_lock = 1'b0;
      h_last = 8'h00;
      g_last = 8'h00;

      apply_reset("reset state");
      g_lock = 1'b1;
      push_h(1'b0, 16'h0010, 8'h00, 8'hA5);
      expect_grants("H");
      run("host read", 1);

      apply_reset("reset 2");
      push_h(1'b1, 16'h1234, 8'h5A, 8'h00);
      push_g(1'b0, 16'h0200, 8'h00, 8'h77);
      expect_grants("HG");
      run("simultaneous", 2);

      apply_reset("reset 3");
      for (int i = 0; i < 8; i++) begin
         push_h(1'b1, 16'h4000 + 16'(i), 8'(i), 8'h00);
         push_g(1'b0, 16'h0300 + 16'(i), 8'h00, 8'h80 + 8'(i));
      end
      expect_grants("HGHGHGHGHGHGHGHG");
      run("alternation", 16);

      apply_reset("reset 4");
      g_lock = 1'b1;
      for (int i = 0; i < 3; i++) push_h(1'b1, 16'h4100 + 16'(i), 8'hC0 + 8'(i), 8'h00);
      for (int i = 0; i < 12; i++) push_g(1'b1, 16'h5000 + 16'(i), 8'h10 + 8'(i), 8'h00);
      expect_grants("HGGGGHGGGGHGGGG");
      run("locked burst", 15);
      g_lock = 1'b0;

      apply_reset("reset 5");
      push_g(1'b0, 16'h0100, 8'h00, 8'h11);
      push_g(1'b0, 16'h0101, 8'h00, 8'h22);
      push_g(1'b0, 16'h0102, 8'h00, 8'h33);
      push_g(1'b0, 16'h0103, 8'h00, 8'h44);
      push_g(1'b0, 16'h1234, 8'h00, 8'h5A);
      expect_grants("GGGGG");
      run("gpu back-to-back", 5);

      // Read in flight when reset hits: the return must be dropped.
      exp_grant.push_back('{port: 1'b1, cmd: '{we: 1'b0, addr: 16'h0010, wdata: 8'h00, rexp: 8'hA5}});
      g_req = 1'b1; g_we = 1'b0; g_addr = 16'h0010;
      @(negedge clk);
      @(posedge clk);
      #1;
      g_req = 1'b0;
      chk("in-flight mem_read", 64'({mem_read, mem_addr}), 64'({1'b1, 16'h0010}));
      #2;
      rst_n = 1'b0;
      h_req = 1'b1;
      g_req = 1'b1;
      flush_scoreboard();
      #1;
      check_reset_outputs("mid-flight reset");
      repeat (2) @(posedge clk);
      #1;
      h_req = 1'b0;
      g_req = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no rvalid after reset", 64'({h_rvalid, g_rvalid, mem_read, mem_write}), 64'(0));
      end
      @(posedge clk);
      #1;
      push_h(1'b1, 16'h6000, 8'h01, 8'h00);
      push_g(1'b1, 16'h6001, 8'h02, 8'h00);
      expect_grants("HG");
      run("tie after reset", 2);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
